auto_gain_sequencer: RTL and testbench

AUTO_GAIN_SEQUENCER -- requirements
Module: auto_gain_sequencer

---
 rtl/auto_gain_sequencer_if.sv | 27 ++
 rtl/auto_gain_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_auto_gain_sequencer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/auto_gain_sequencer_if.sv
// ---------------------------------------------------------------------------
// auto_gain_sequencer_if
// Avalon-MM register bus for the auto gain sequencer.
//   address    : register select (0..7)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data
//   readdata   : zero-wait-state read data, driven by the slave
// Modports: master (bus owner / CPU side), slave (the sequencer).
// ---------------------------------------------------------------------------
interface auto_gain_sequencer_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/auto_gain_sequencer.sv
// ---------------------------------------------------------------------------
// auto_gain_sequencer
// Drives a 5-bit PGA gain code. In manual mode software writes the gain; in
// auto mode a four-state sequencer (IDLE/SETTLE/MEASURE/DECIDE) waits for the
// analog path to settle, takes the peak magnitude over a window of samples
// and steps the gain by one toward the band [LO_TH, HI_TH].
// Ports:
//   clk          : clock, all logic on the rising edge
//   reset_n      : synchronous active-low reset
//   avs          : Avalon-MM slave register bus (see auto_gain_sequencer_if)
//   sample_valid : qualifies sample_data
//   sample_data  : signed two's-complement ADC sample
//   gain_out     : PGA gain code
//   gain_changed : one-cycle pulse in the first cycle gain_out shows a new value
// Registers: 0 CTRL, 1 GAIN, 2 HI_TH, 3 LO_TH, 4 WINDOW, 5 SETTLE, 6 LIMITS,
//            7 STATUS {state[6:4], overload[3] W1C, settling, at_max, at_min}.
// ---------------------------------------------------------------------------
module auto_gain_sequencer (
  input  logic                        clk,
  input  logic                        reset_n,
  auto_gain_sequencer_if.slave        avs,
  input  logic                        sample_valid,
  input  logic signed [15:0]          sample_data,
  output logic [4:0]                  gain_out,
  output logic                        gain_changed
);

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DECIDE  = 2'd3
  } state_t;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_GAIN   = 3'd1;
  localparam logic [2:0] A_HI_TH  = 3'd2;
  localparam logic [2:0] A_LO_TH  = 3'd3;
  localparam logic [2:0] A_WINDOW = 3'd4;
  localparam logic [2:0] A_SETTLE = 3'd5;
  localparam logic [2:0] A_LIMITS = 3'd6;
  localparam logic [2:0] A_STATUS = 3'd7;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_auto_en;
  logic [4:0]  r_gain;
  logic        r_gain_chg;
  logic [15:0] r_hi_th;
  logic [15:0] r_lo_th;
  logic [15:0] r_window;
  logic [15:0] r_settle;
  logic [4:0]  r_gmin;
  logic [4:0]  r_gmax;
  logic        r_overload;
  logic [15:0] r_settle_cnt;
  logic [15:0] r_win_cnt;
  logic [DATA_W-1:0] r_peak;

  logic              w_wr;
  logic [DATA_W-1:0] w_mag;
  logic [16:0]       w_cnt_inc;
  logic [16:0]       w_win_eff;
  logic              w_accept;
  logic              w_load_settle;
  logic              w_clr_win;
  logic              w_step_dn;
  logic              w_step_up;
  logic              w_man_wr;
  logic              w_ovl_set;
  logic              w_ovl_clr;
  logic [4:0]        w_gain_nxt;
  logic              w_at_min;
  logic              w_at_max;
  logic              w_settling;
  logic              w_unused_wdata;

  // |s| saturated to the positive range: the most negative code has no
  // positive twin, so it maps to the largest positive magnitude.
  function automatic logic [DATA_W-1:0] sat_abs(input logic signed [DATA_W-1:0] s);
    logic signed [DATA_W-1:0] neg;
    neg = -s;
    if (!s[DATA_W-1])
      return s;
    else if (s[DATA_W-2:0] == '0)
      return {1'b0, {(DATA_W-1){1'b1}}};
    else
      return neg;
  endfunction

  assign w_wr           = avs.chipselect && !avs.write_n;
  assign w_mag          = sat_abs(sample_data);
  assign w_cnt_inc      = {1'b0, r_win_cnt} + 17'd1;
  assign w_win_eff      = (r_window == 16'd0) ? 17'd1 : {1'b0, r_window};
  assign w_accept       = r_auto_en && (r_state == ST_MEASURE) && sample_valid;
  assign w_man_wr       = w_wr && (avs.address == A_GAIN) && !r_auto_en;
  assign w_ovl_set      = (r_state == ST_MEASURE) && sample_valid && (w_mag == 16'h7FFF);
  assign w_ovl_clr      = w_wr && (avs.address == A_STATUS) && avs.writedata[3];
  assign w_at_min       = (r_gain <= r_gmin);
  assign w_at_max       = (r_gain >= r_gmax);
  assign w_settling     = (r_state == ST_SETTLE);
  assign w_unused_wdata = ^avs.writedata[31:16];

  assign gain_out     = r_gain;
  assign gain_changed = r_gain_chg;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Clearing auto_en overrides every state; the window in progress is simply
  // dropped because MEASURE clears peak/count on each entry.
  always_comb begin
    w_state_nxt   = r_state;
    w_load_settle = 1'b0;
    w_clr_win     = 1'b0;
    w_step_dn     = 1'b0;
    w_step_up     = 1'b0;
    if (!r_auto_en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt   = ST_SETTLE;
          w_load_settle = 1'b1;
        end
        ST_SETTLE: begin
          if (r_settle_cnt == 16'd0) begin
            w_state_nxt = ST_MEASURE;
            w_clr_win   = 1'b1;
          end
        end
        ST_MEASURE: begin
          // >= so that shrinking WINDOW mid-window still terminates it
          if (sample_valid && (w_cnt_inc >= w_win_eff))
            w_state_nxt = ST_DECIDE;
        end
        ST_DECIDE: begin
          // gain > gmin implies gain >= 1 and gain < gmax implies gain <= 30,
          // so the step can never wrap.
          if ((r_peak > r_hi_th) && (r_gain > r_gmin)) begin
            w_step_dn     = 1'b1;
            w_state_nxt   = ST_SETTLE;
            w_load_settle = 1'b1;
          end else if ((r_peak < r_lo_th) && (r_gain < r_gmax)) begin
            w_step_up     = 1'b1;
            w_state_nxt   = ST_SETTLE;
            w_load_settle = 1'b1;
          end else begin
            w_state_nxt = ST_MEASURE;
            w_clr_win   = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_gain_nxt = r_gain;
    if (w_step_dn)      w_gain_nxt = r_gain - 5'd1;
    else if (w_step_up) w_gain_nxt = r_gain + 5'd1;
    else if (w_man_wr)  w_gain_nxt = avs.writedata[4:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_auto_en    <= 1'b0;
      r_gain       <= 5'd0;
      r_gain_chg   <= 1'b0;
      r_hi_th      <= 16'h6000;
      r_lo_th      <= 16'h1800;
      r_window     <= 16'd1024;
      r_settle     <= 16'd256;
      r_gmin       <= 5'd0;
      r_gmax       <= 5'd31;
      r_overload   <= 1'b0;
      r_settle_cnt <= 16'd0;
      r_win_cnt    <= 16'd0;
      r_peak       <= '0;
    end else begin
      if (w_wr) begin
        case (avs.address)
          A_CTRL:   r_auto_en <= avs.writedata[0];
          A_HI_TH:  r_hi_th   <= avs.writedata[15:0];
          A_LO_TH:  r_lo_th   <= avs.writedata[15:0];
          A_WINDOW: r_window  <= avs.writedata[15:0];
          A_SETTLE: r_settle  <= avs.writedata[15:0];
          A_LIMITS: begin
            r_gmin <= avs.writedata[4:0];
            r_gmax <= avs.writedata[12:8];
          end
          default: ;
        endcase
      end

      // The pulse is registered alongside the gain so both appear together;
      // rewriting the current value produces no edge.
      r_gain     <= w_gain_nxt;
      r_gain_chg <= (w_gain_nxt != r_gain);

      r_overload <= w_ovl_set | (r_overload & ~w_ovl_clr);

      if (w_load_settle)
        r_settle_cnt <= r_settle;
      else if ((r_state == ST_SETTLE) && (r_settle_cnt != 16'd0))
        r_settle_cnt <= r_settle_cnt - 16'd1;

      if (w_clr_win) begin
        r_peak    <= '0;
        r_win_cnt <= 16'd0;
      end else if (w_accept) begin
        if (w_mag > r_peak) r_peak <= w_mag;
        r_win_cnt <= w_cnt_inc[15:0];
      end
    end
  end

  always_comb begin
    avs.readdata = '0;
    case (avs.address)
      A_CTRL:   avs.readdata[0]    = r_auto_en;
      A_GAIN:   avs.readdata[4:0]  = r_gain;
      A_HI_TH:  avs.readdata[15:0] = r_hi_th;
      A_LO_TH:  avs.readdata[15:0] = r_lo_th;
      A_WINDOW: avs.readdata[15:0] = r_window;
      A_SETTLE: avs.readdata[15:0] = r_settle;
      A_LIMITS: begin
        avs.readdata[4:0]  = r_gmin;
        avs.readdata[12:8] = r_gmax;
      end
      A_STATUS: avs.readdata[6:0] = {1'b0, r_state, r_overload, w_settling, w_at_max, w_at_min};
      default:  avs.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_auto_gain_sequencer.sv
// ---------------------------------------------------------------------------
// tb_auto_gain_sequencer
// Drives the sequencer through directed scenarios and randomized auto-mode
// runs. A window-level reference model predicts every gain change; expected
// gains go into a queue that a negedge monitor pops on each gain_changed.
// ---------------------------------------------------------------------------
module tb_auto_gain_sequencer;
  logic               clk = 1'b0;
  logic               reset_n;
  logic               sample_valid;
  logic signed [15:0] sample_data;
  logic [4:0]         gain_out;
  logic               gain_changed;

  always #5 clk = ~clk;

  auto_gain_sequencer_if bus ();

  auto_gain_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .avs          (bus),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .gain_out     (gain_out),
    .gain_changed (gain_changed)
  );

  localparam logic signed [15:0] JUNK = 16'sh7FFF;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  bit mon_en = 1'b0;
  logic [4:0] prev_gain = 5'd0;

  // reference model state
  int m_auto, m_gain, m_gmin, m_gmax, m_hi, m_lo, m_win, m_settle;

  task automatic model_reset();
    m_auto = 0; m_gain = 0; m_gmin = 0; m_gmax = 31;
    m_hi = 24576; m_lo = 6144; m_win = 1024; m_settle = 256;
  endtask

  function automatic int mag(input logic signed [15:0] s);
    int v;
    v = int'(s);
    if (v < 0) v = -v;
    return (v > 32767) ? 32767 : v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    int e;
    if (mon_en) begin
      if (gain_changed === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL gain_pulse: got pulse with gain_out=%0d, required no pulse", gain_out);
        end else begin
          e = exp_q.pop_front();
          if (gain_out !== 5'(e)) begin
            errors++;
            $display("FAIL gain_value: got %0d, required %0d", gain_out, e);
          end
        end
      end else if (gain_out !== prev_gain) begin
        checks++;
        errors++;
        $display("FAIL gain_silent: got change %0d->%0d without pulse, required pulse", prev_gain, gain_out);
      end
    end
    prev_gain = gain_out;
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
    sample_valid = 1'b0;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = 3'd7;
  endtask

  task automatic rd_chk(input string nm, input logic [2:0] a, input logic [31:0] exp);
    @(negedge clk);
    bus.address = a; sample_valid = 1'b0;
    #1;
    chk(nm, bus.readdata, exp);
    bus.address = 3'd7;
  endtask

  // Checks the FSM state seen since the last edge (exp_st < 0: skip), then
  // presents one sample for the next edge. Address idles at STATUS.
  task automatic drive(input bit v, input logic signed [15:0] d, input int exp_st);
    @(negedge clk);
    if (exp_st >= 0) chk("fsm_state", 32'(bus.readdata[6:4]), 32'(exp_st));
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = 3'd7;
    sample_valid = v; sample_data = d;
  endtask

  task automatic set_reg(input logic [2:0] a, input int v);
    case (a)
      3'd0: m_auto = v & 1;
      3'd1: if (m_auto == 0) begin
              if ((v & 31) != m_gain) exp_q.push_back(v & 31);
              m_gain = v & 31;
            end
      3'd2: m_hi = v & 16'hFFFF;
      3'd3: m_lo = v & 16'hFFFF;
      3'd4: m_win = v & 16'hFFFF;
      3'd5: m_settle = v & 16'hFFFF;
      3'd6: begin m_gmin = v & 31; m_gmax = (v >> 8) & 31; end
      default: ;
    endcase
    wr(a, 32'(v));
  endtask

  task automatic auto_off();
    set_reg(3'd0, 0);
    drive(1'b0, 16'sd0, -1);
    drive(1'b0, 16'sd0, 0);
  endtask

  // Enables auto mode and feeds nwin full windows. Timeline: 1 IDLE cycle,
  // SETTLE+1 settle cycles, WINDOW samples, 1 DECIDE cycle, then SETTLE+1
  // more settle cycles only if the gain moved. Junk is fed wherever samples
  // must be ignored.
  task automatic run_auto(input int nwin, input bit rnd, input logic signed [15:0] fval);
    int weff, peak, mode;
    bit changed;
    logic signed [15:0] s;
    weff = (m_win == 0) ? 1 : m_win;
    set_reg(3'd0, 1);
    for (int k = 0; k < m_settle + 2; k++) drive(1'b1, JUNK, (k == 0) ? 0 : 1);
    for (int w = 0; w < nwin; w++) begin
      peak = 0;
      mode = $urandom_range(0, 2);
      for (int j = 0; j < weff; j++) begin
        if (!rnd) s = fval;
        else if (mode == 0) s = 16'($urandom_range(0, 16'h0FFF));
        else if (mode == 1) s = 16'($urandom_range(16'h2000, 16'h5000));
        else s = 16'($urandom);
        if (rnd && $urandom_range(0, 1) == 1 && mode != 2) s = -s;
        if (mag(s) > peak) peak = mag(s);
        drive(1'b1, s, 2);
      end
      changed = 1'b0;
      if (peak > m_hi && m_gain > m_gmin) begin m_gain--; changed = 1'b1; end
      else if (peak < m_lo && m_gain < m_gmax) begin m_gain++; changed = 1'b1; end
      if (changed) exp_q.push_back(m_gain);
      drive(1'b1, JUNK, 3);
      if (changed) for (int k = 0; k <= m_settle; k++) drive(1'b1, JUNK, 1);
    end
    drive(1'b0, 16'sd0, 2);
  endtask

  task automatic rd_defaults(input string tag);
    rd_chk({tag, "_ctrl"},   3'd0, 32'h0);
    rd_chk({tag, "_gain"},   3'd1, 32'h0);
    rd_chk({tag, "_hi"},     3'd2, 32'h6000);
    rd_chk({tag, "_lo"},     3'd3, 32'h1800);
    rd_chk({tag, "_window"}, 3'd4, 32'd1024);
    rd_chk({tag, "_settle"}, 3'd5, 32'd256);
    rd_chk({tag, "_limits"}, 3'd6, 32'h1F00);
    rd_chk({tag, "_status"}, 3'd7, 32'h1);
  endtask

  initial begin
    int lo, hi, gmn, gmx;
    reset_n = 1'b0; sample_valid = 1'b0; sample_data = 16'sd0;
    bus.address = 3'd7; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'h0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // reset state
    chk("rst_gain_out", 32'(gain_out), 32'd0);
    chk("rst_gain_changed", 32'(gain_changed), 32'd0);
    rd_defaults("rst");

    // manual writes, identical rewrite, no clamping to limits
    set_reg(3'd1, 32'h0A);
    drive(1'b0, 16'sd0, -1);
    chk("manual_gain", 32'(gain_out), 32'd10);
    set_reg(3'd1, 32'h0A);
    drive(1'b0, 16'sd0, -1);
    drive(1'b0, 16'sd0, -1);
    rd_chk("manual_gain_reg", 3'd1, 32'h0A);
    set_reg(3'd6, 5 | (20 << 8));
    set_reg(3'd1, 25);
    rd_chk("manual_noclamp", 3'd1, 32'd25);
    set_reg(3'd6, 31 << 8);

    // step up with junk during SETTLE
    set_reg(3'd1, 5);
    set_reg(3'd4, 4);
    set_reg(3'd5, 2);
    set_reg(3'd3, 16'h1800);
    run_auto(1, 1'b0, 16'sh0100);
    chk("stepup_gain", 32'(gain_out), 32'd6);
    auto_off();

    // gain held at gmin by overload-level samples
    set_reg(3'd1, 3);
    set_reg(3'd6, 3 | (31 << 8));
    run_auto(1, 1'b0, 16'sh8000);
    chk("limit_gain", 32'(gain_out), 32'd3);
    auto_off();
    rd_chk("ovl_status", 3'd7, 32'h09);
    set_reg(3'd7, 32'h8);
    rd_chk("ovl_cleared", 3'd7, 32'h01);

    // hysteresis band, then GAIN write ignored in auto mode
    set_reg(3'd6, 31 << 8);
    run_auto(3, 1'b0, 16'sh3000);
    chk("hyst_gain", 32'(gain_out), 32'd3);
    set_reg(3'd1, 0);
    drive(1'b0, 16'sd0, -1);
    chk("auto_gain_write_ignored", 32'(gain_out), 32'd3);
    auto_off();

    // abort mid-window, then restart with a fresh peak
    set_reg(3'd1, 5);
    set_reg(3'd0, 1);
    for (int k = 0; k < m_settle + 2; k++) drive(1'b1, JUNK, (k == 0) ? 0 : 1);
    drive(1'b1, 16'sh7000, 2);
    drive(1'b1, 16'sh7000, 2);
    set_reg(3'd0, 0);
    drive(1'b0, 16'sd0, 2);
    drive(1'b0, 16'sd0, 0);
    chk("abort_gain", 32'(gain_out), 32'd5);
    run_auto(1, 1'b0, 16'sh0100);
    chk("restart_gain", 32'(gain_out), 32'd6);
    auto_off();

    // randomized configurations
    for (int r = 0; r < 6; r++) begin
      lo  = $urandom_range(16'h0400, 16'h2000);
      hi  = $urandom_range(16'h3000, 16'h7800);
      gmn = $urandom_range(0, 12);
      gmx = $urandom_range(18, 31);
      set_reg(3'd5, $urandom_range(0, 3));
      set_reg(3'd4, $urandom_range(0, 5));
      set_reg(3'd3, lo);
      set_reg(3'd2, hi);
      set_reg(3'd6, gmn | (gmx << 8));
      set_reg(3'd1, $urandom_range(0, 31));
      run_auto(8, 1'b1, 16'sd0);
      chk("random_gain", 32'(gain_out), 32'(m_gain));
      auto_off();
    end
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    // reset in the middle of SETTLE
    set_reg(3'd5, 20);
    set_reg(3'd1, 7);
    set_reg(3'd0, 1);
    for (int k = 0; k < 5; k++) drive(1'b1, JUNK, (k == 0) ? 0 : 1);
    @(negedge clk);
    mon_en = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    chk("midreset_gain_changed", 32'(gain_changed), 32'd0);
    chk("midreset_gain_out", 32'(gain_out), 32'd0);
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
    mon_en = 1'b1;
    chk("midreset_gain_changed2", 32'(gain_changed), 32'd0);
    rd_defaults("midreset");
    repeat (4) drive(1'b1, JUNK, 0);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
